// File: rtl/input_buffer_nch.sv
// Multi-channel activation input buffer: one circular FIFO per channel, read as a
// NUM_RDATA-word window with a shared strided pop. Optional error flags: INPUT_BUFFER_NCH_ERR_EN.
module input_buffer_nch #(
  parameter int DAT_WIDTH     = 8,
  parameter int NUM_CHANNEL   = 4,
  parameter int NUM_RDATA     = 3,
  parameter int FF_DEPTH      = 16,
  parameter int FF_ADDR_WIDTH = 4,
  parameter int STR_WIDTH     = 2
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [DAT_WIDTH*NUM_CHANNEL-1:0]           i_data,
  input  logic [NUM_CHANNEL-1:0]                     i_data_val,
  input  logic                                       i_data_req,
  input  logic [STR_WIDTH-1:0]                       i_rd_stride,
  input  logic                                       i_flush,
  output logic [DAT_WIDTH*NUM_RDATA*NUM_CHANNEL-1:0] o_data,
  output logic                                       o_data_val,
  output logic                                       o_rd_rdy,
  output logic [(FF_ADDR_WIDTH+1)*NUM_CHANNEL-1:0]   o_data_counter,
  output logic                                       o_empty,
  output logic                                       o_full,
  output logic [NUM_CHANNEL-1:0]                     o_err_ovf,
  output logic                                       o_err_udf
);

  localparam int AW = FF_ADDR_WIDTH;
  localparam int CW = FF_ADDR_WIDTH + 1;

  logic [NUM_CHANNEL-1:0]                     ch_rdy;
  logic [NUM_CHANNEL-1:0]                     ch_empty;
  logic [NUM_CHANNEL-1:0]                     ch_full;
  logic [DAT_WIDTH*NUM_RDATA*NUM_CHANNEL-1:0] window_flat;
  logic [CW-1:0]                              stride_eff;
  logic                                       rd_acc;

  // Stride is clamped to the window size so a read never pops unseen entries.
  always_comb begin
    stride_eff = CW'(i_rd_stride);
    if (int'(i_rd_stride) > NUM_RDATA)
      stride_eff = CW'(NUM_RDATA);
  end

  assign o_rd_rdy = &ch_rdy;
  assign rd_acc   = i_data_req & o_rd_rdy;
  assign o_empty  = &ch_empty;
  assign o_full   = |ch_full;

  genvar gi, gk;
  generate
    for (gi = 0; gi < NUM_CHANNEL; gi++) begin : g_ch
      logic [DAT_WIDTH-1:0] mem [FF_DEPTH];
      logic [AW-1:0]        wptr_reg;
      logic [AW-1:0]        rptr_reg;
      logic [CW-1:0]        cnt_reg;
      logic [CW-1:0]        cnt_next;
      logic                 wr_en;

      // A full channel drops the write even when a pop frees space this cycle.
      assign wr_en    = i_data_val[gi] && (cnt_reg < CW'(FF_DEPTH));
      assign cnt_next = cnt_reg + CW'(wr_en) - (rd_acc ? stride_eff : '0);

      always_ff @(posedge clk) begin
        if (rst || i_flush) begin
          wptr_reg <= '0;
          rptr_reg <= '0;
          cnt_reg  <= '0;
        end else begin
          if (wr_en)
            wptr_reg <= wptr_reg + 1'b1;
          if (rd_acc)
            rptr_reg <= rptr_reg + stride_eff[AW-1:0];
          cnt_reg <= cnt_next;
        end
      end

      always_ff @(posedge clk) begin
        if (wr_en)
          mem[wptr_reg] <= i_data[gi*DAT_WIDTH +: DAT_WIDTH];
      end

      // The write slot sits at rptr+count, so it never aliases a window word.
      for (gk = 0; gk < NUM_RDATA; gk++) begin : g_win
        assign window_flat[(gi*NUM_RDATA+gk)*DAT_WIDTH +: DAT_WIDTH] = mem[rptr_reg + AW'(gk)];
      end

      assign o_data_counter[gi*CW +: CW] = cnt_reg;
      assign ch_rdy[gi]   = cnt_reg >= CW'(NUM_RDATA);
      assign ch_empty[gi] = cnt_reg == '0;
      assign ch_full[gi]  = cnt_reg == CW'(FF_DEPTH);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      o_data     <= '0;
      o_data_val <= 1'b0;
    end else if (i_flush) begin
      o_data_val <= 1'b0;
    end else begin
      o_data_val <= rd_acc;
      if (rd_acc)
        o_data <= window_flat;
    end
  end

`ifdef INPUT_BUFFER_NCH_ERR_EN
  logic [NUM_CHANNEL-1:0] ovf_reg;
  logic                   udf_reg;

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      ovf_reg <= '0;
      udf_reg <= 1'b0;
    end else begin
      ovf_reg <= ovf_reg | (i_data_val & ch_full);
      if (i_data_req && !o_rd_rdy)
        udf_reg <= 1'b1;
    end
  end

  assign o_err_ovf = ovf_reg;
  assign o_err_udf = udf_reg;
`else
  assign o_err_ovf = '0;
  assign o_err_udf = 1'b0;
`endif

endmodule

// File: tb/tb_input_buffer_nch.sv
// Self-checking bench for input_buffer_nch: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_input_buffer_nch;

  localparam int DW  = 8;
  localparam int NCH = 4;
  localparam int NR  = 3;
  localparam int DEP = 16;
  localparam int CW  = 5;
`ifdef INPUT_BUFFER_NCH_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic [DW*NCH-1:0]      i_data;
  logic [NCH-1:0]         i_data_val;
  logic                   i_data_req;
  logic [1:0]             i_rd_stride;
  logic                   i_flush;
  logic [DW*NR*NCH-1:0]   o_data;
  logic                   o_data_val;
  logic                   o_rd_rdy;
  logic [CW*NCH-1:0]      o_data_counter;
  logic                   o_empty;
  logic                   o_full;
  logic [NCH-1:0]         o_err_ovf;
  logic                   o_err_udf;

  input_buffer_nch #(
    .DAT_WIDTH(DW), .NUM_CHANNEL(NCH), .NUM_RDATA(NR),
    .FF_DEPTH(DEP), .FF_ADDR_WIDTH(4), .STR_WIDTH(2)
  ) dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_data_val(i_data_val),
    .i_data_req(i_data_req), .i_rd_stride(i_rd_stride), .i_flush(i_flush),
    .o_data(o_data), .o_data_val(o_data_val), .o_rd_rdy(o_rd_rdy),
    .o_data_counter(o_data_counter), .o_empty(o_empty), .o_full(o_full),
    .o_err_ovf(o_err_ovf), .o_err_udf(o_err_udf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Reference model: plain queues of stored words per channel.
  logic [DW-1:0]        mq [NCH][$];
  logic [DW*NR*NCH-1:0] exp_data;
  logic                 exp_val;
  logic [NCH-1:0]       exp_ovf;
  logic                 exp_udf;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_apply();
    int  sz [NCH];
    bit  rdy;
    int  s;
    if (rst) begin
      for (int c = 0; c < NCH; c++) mq[c].delete();
      exp_data = '0; exp_val = 1'b0; exp_ovf = '0; exp_udf = 1'b0;
    end else if (i_flush) begin
      for (int c = 0; c < NCH; c++) mq[c].delete();
      exp_val = 1'b0; exp_ovf = '0; exp_udf = 1'b0;
    end else begin
      rdy = 1'b1;
      for (int c = 0; c < NCH; c++) begin
        sz[c] = mq[c].size();
        if (sz[c] < NR) rdy = 1'b0;
      end
      exp_val = i_data_req && rdy;
      if (i_data_req && !rdy && ERR_EN) exp_udf = 1'b1;
      if (exp_val) begin
        s = (int'(i_rd_stride) > NR) ? NR : int'(i_rd_stride);
        for (int c = 0; c < NCH; c++) begin
          for (int k = 0; k < NR; k++) exp_data[(c*NR+k)*DW +: DW] = mq[c][k];
          for (int j = 0; j < s; j++) void'(mq[c].pop_front());
        end
      end
      for (int c = 0; c < NCH; c++) begin
        if (i_data_val[c]) begin
          if (sz[c] < DEP) mq[c].push_back(i_data[c*DW +: DW]);
          else if (ERR_EN) exp_ovf[c] = 1'b1;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      bit r, e, f;
      r = 1'b1; e = 1'b1; f = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        chk($sformatf("count_ch%0d", c), o_data_counter[c*CW +: CW], mq[c].size());
        if (mq[c].size() < NR) r = 1'b0;
        if (mq[c].size() != 0) e = 1'b0;
        if (mq[c].size() == DEP) f = 1'b1;
      end
      chk("o_data_val", o_data_val, exp_val);
      chk("o_data", o_data, exp_data);
      chk("o_rd_rdy", o_rd_rdy, r);
      chk("o_empty", o_empty, e);
      chk("o_full", o_full, f);
      chk("o_err_ovf", o_err_ovf, exp_ovf);
      chk("o_err_udf", o_err_udf, exp_udf);
      if (exp_val) $display("read window %h at %0t", o_data, $time);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_apply();
    check_en = 1'b1;
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; i_flush = 1'b0; i_data_val = '0; i_data_req = 1'b0; i_rd_stride = 2'd1;
  endtask

  task automatic write_all(input logic [DW-1:0] v);
    i_data = {NCH{v}}; i_data_val = '1; tick(); i_data_val = '0;
  endtask

  task automatic read(input logic [1:0] s);
    i_data_req = 1'b1; i_rd_stride = s; tick(); i_data_req = 1'b0;
  endtask

  task automatic flush();
    i_flush = 1'b1; tick(); i_flush = 1'b0;
  endtask

  task automatic chk_win(input string name, input logic [DW-1:0] w0, input logic [DW-1:0] w1, input logic [DW-1:0] w2);
    for (int c = 0; c < NCH; c++) begin
      chk(name, o_data[(c*NR+0)*DW +: DW], w0);
      chk(name, o_data[(c*NR+1)*DW +: DW], w1);
      chk(name, o_data[(c*NR+2)*DW +: DW], w2);
    end
  endtask

  initial begin
    i_data = '0;
    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("reset_empty", o_empty, 1'b1);
    chk("reset_counts", o_data_counter, '0);
    chk("reset_val", o_data_val, 1'b0);

    // Basic window read
    for (int i = 0; i < 4; i++) write_all(8'h10 + 8'(i));
    read(2'd1);
    $display("directed basic read done");
    chk("basic_val", o_data_val, 1'b1);
    chk_win("basic_window", 8'h10, 8'h11, 8'h12);
    for (int c = 0; c < NCH; c++) chk("basic_count", o_data_counter[c*CW +: CW], 5'd3);
    tick();
    chk("basic_pulse_end", o_data_val, 1'b0);

    // Overflow on channel 0
    flush();
    for (int i = 0; i < DEP; i++) begin
      i_data = {NCH{8'(i)}}; i_data_val = 4'b0001; tick();
    end
    i_data = {NCH{8'hAA}}; tick(); i_data_val = '0;
    $display("directed overflow done");
    chk("ovf_count", o_data_counter[CW-1:0], 5'd16);
    chk("ovf_full", o_full, 1'b1);
    chk("ovf_flag", o_err_ovf[0], ERR_EN);

    // Early read is ignored
    flush();
    write_all(8'h01); write_all(8'h02);
    read(2'd1);
    $display("directed underflow done");
    chk("udf_rdy", o_rd_rdy, 1'b0);
    chk("udf_val", o_data_val, 1'b0);
    chk("udf_count", o_data_counter[CW-1:0], 5'd2);
    chk("udf_flag", o_err_udf, ERR_EN);

    // Pointer wrap: read pointer ends at 15, entries 16.. land at addresses 0..
    flush();
    for (int i = 0; i < DEP; i++) write_all(8'(i));
    for (int i = 0; i < 5; i++) read(2'd3);
    for (int i = DEP; i < 20; i++) write_all(8'(i));
    read(2'd3);
    $display("directed wrap done");
    chk_win("wrap_window", 8'h0F, 8'h10, 8'h11);

    // Full channel: write dropped while popping, then peeks
    flush();
    for (int i = 0; i < DEP; i++) write_all(8'(i));
    i_data = {NCH{8'hEE}}; i_data_val = '1; i_data_req = 1'b1; i_rd_stride = 2'd3;
    tick(); idle();
    chk("fullrw_count", o_data_counter[CW-1:0], 5'd13);
    chk_win("fullrw_window", 8'h00, 8'h01, 8'h02);
    read(2'd0);
    chk_win("peek1_window", 8'h03, 8'h04, 8'h05);
    read(2'd0);
    $display("directed peek done");
    chk_win("peek2_window", 8'h03, 8'h04, 8'h05);
    chk("peek_val", o_data_val, 1'b1);
    chk("peek_count", o_data_counter[CW-1:0], 5'd13);

    // Flush and reset colliding with an accepted read
    flush();
    for (int i = 0; i < 5; i++) write_all(8'h50 + 8'(i));
    i_data_req = 1'b1; i_flush = 1'b1; tick(); idle();
    chk("flushrd_val", o_data_val, 1'b0);
    chk("flushrd_empty", o_empty, 1'b1);
    chk("flushrd_count", o_data_counter, '0);
    for (int i = 0; i < 5; i++) write_all(8'h60 + 8'(i));
    i_data_req = 1'b1; rst = 1'b1; tick(); idle();
    $display("directed flush/reset done");
    chk("rstrd_val", o_data_val, 1'b0);
    chk("rstrd_empty", o_empty, 1'b1);
    chk("rstrd_data", o_data, '0);

    // Randomized traffic with alternating write-heavy and read-heavy phases
    for (int n = 0; n < 1200; n++) begin
      rst        = ($urandom_range(0, 299) == 0);
      i_flush    = ($urandom_range(0, 79) == 0);
      i_data     = $urandom();
      i_data_val = ((n / 100) % 2 == 0) ? 4'($urandom() | $urandom()) : 4'($urandom() & $urandom());
      i_data_req = $urandom_range(0, 1) == 1;
      i_rd_stride = 2'($urandom_range(0, 3));
      tick();
    end
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/input_buffer_nch.md
INPUT_BUFFER_NCH -- requirements
Module: input_buffer_nch

Interface
REQ-001 SHALL have parameter DAT_WIDTH, default 8: bits per activation word.
REQ-002 SHALL have parameter NUM_CHANNEL, default 4: independent channel FIFOs.
REQ-003 SHALL have parameter NUM_RDATA, default 3: words per channel per read (window size).
REQ-004 SHALL have parameters FF_DEPTH = 16 (entries per channel) and FF_ADDR_WIDTH = 4; FF_DEPTH = 2**FF_ADDR_WIDTH and NUM_RDATA <= FF_DEPTH are mandatory.
REQ-005 SHALL have parameter STR_WIDTH, default 2: width of the read stride field.
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 clk  in  1  clock, all logic on rising edge.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 i_data  in  DAT_WIDTH*NUM_CHANNEL  write words; channel c at [c*DAT_WIDTH +: DAT_WIDTH].
REQ-010 i_data_val  in  NUM_CHANNEL  per-channel write strobe.
REQ-011 i_data_req  in  1  read request, common to all channels.
REQ-012 i_rd_stride  in  STR_WIDTH  entries popped per accepted read; 0 = peek.
REQ-013 i_flush  in  1  synchronous clear of all channel contents.
REQ-014 o_data  out  DAT_WIDTH*NUM_RDATA*NUM_CHANNEL  window; channel c word k at [(c*NUM_RDATA+k)*DAT_WIDTH +: DAT_WIDTH].
REQ-015 o_data_val  out  1  window valid, one-cycle pulse.
REQ-016 o_rd_rdy  out  1  all channels hold >= NUM_RDATA entries.
REQ-017 o_data_counter  out  (FF_ADDR_WIDTH+1)*NUM_CHANNEL  per-channel occupancy 0..FF_DEPTH.
REQ-018 o_empty  out  1  all channels empty; o_full  out  1  any channel full.
REQ-019 o_err_ovf  out  NUM_CHANNEL  sticky dropped-write flags; o_err_udf  out  1  sticky early-read flag.

Function
REQ-020 Each channel SHALL be a circular buffer with write pointer, read pointer and occupancy count; pointers wrap FF_DEPTH-1 -> 0.
REQ-021 Write: i_data_val[c]=1 and count[c] < FF_DEPTH stores i_data word c at wptr[c], wptr[c]++, count[c]++.
REQ-022 Write to a channel with count[c] = FF_DEPTH SHALL be dropped even if a pop occurs the same cycle; storage unchanged.
REQ-023 o_rd_rdy SHALL be combinational: 1 iff every count[c] >= NUM_RDATA.
REQ-024 Read accepted iff i_data_req=1 and o_rd_rdy=1; next cycle o_data word k of channel c = entry rptr[c]+k (mod FF_DEPTH) and o_data_val=1 (latency 1).
REQ-025 On accept, effective stride s = min(i_rd_stride, NUM_RDATA); every rptr[c] += s, count[c] -= s; s=0 leaves buffers unchanged.
REQ-026 i_data_req with o_rd_rdy=0 SHALL be ignored: o_data_val=0, o_data holds last value, no pointer change.
REQ-027 Simultaneous accepted write and read on a channel: count[c] <= count[c] + 1 - s.
REQ-028 o_data_val SHALL be 0 in any cycle not following an accepted read; o_data holds its value.
REQ-029 o_empty = 1 iff all count[c] = 0; o_full = 1 iff any count[c] = FF_DEPTH.
REQ-030 i_flush SHALL zero all pointers and counts next cycle, override same-cycle writes and reads, force o_data_val=0 next cycle, keep o_data.

Reset
REQ-031 rst SHALL clear all pointers, counts, o_data, o_data_val, o_err_ovf, o_err_udf to 0 next edge; rst overrides i_flush, writes and reads.
REQ-032 rst mid-read SHALL suppress the pending o_data_val pulse.

Configuration
REQ-033 Macro INPUT_BUFFER_NCH_ERR_EN defined: o_err_ovf[c] sets on a REQ-022 dropped write; o_err_udf sets on a REQ-026 ignored request; both cleared only by rst or i_flush.
REQ-034 Macro undefined: o_err_ovf and o_err_udf ports SHALL remain and be constant 0; no error logic synthesised.

Verification
REQ-035 Write 0x10..0x13 to all 4 channels, req stride 1 -> next cycle each channel window {0x10,0x11,0x12}, o_data_val=1, counts 3.
REQ-036 Fill channel 0 with 16 words then write 0xAA -> dropped, count 16, o_full=1, o_err_ovf[0]=1 with ERR_EN, 0 without.
REQ-037 Only 2 entries per channel, req -> o_rd_rdy=0, no o_data_val, counts unchanged, o_err_udf=1 with ERR_EN.
REQ-038 Pointer wrap: write 20, read stride 3 interleaved so rptr crosses 15 -> window {e15,e0,e1} in order.
REQ-039 Full channel, same cycle write + read stride 3 -> write dropped, count 13; stride 0 peek -> count unchanged, window repeated.
REQ-040 Flush and rst during pending read with 5 entries stored -> counts 0, o_empty=1, o_data_val=0 next cycle.
